// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO feeding a UART transmitter through a wr/data/rdy handshake.
// A four-state drain sequencer issues one byte per frame and waits for the frame to finish.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [7:0]    pushData_i,
  input  logic          clrOvf_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o,
  output logic          overflow_o,
  input  logic          txRdy_i,
  output logic          txWr_o,
  output logic [7:0]    txData_o
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  state_t        state;
  logic          pushOk;
  logic          pop;

  assign full_o  = (cnt == FULL_CNT);
  assign empty_o = (cnt == '0);
  assign count_o = cnt;

  assign pushOk = push_i && !full_o && !rst_i;
  // The byte is latched on entry to ISSUE; the pointer/count retire on the edge leaving it.
  assign pop    = (state == ISSUE);

  always_ff @(posedge clk_i) begin
    if (pushOk) begin
      mem[wp] <= pushData_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp         <= '0;
      rp         <= '0;
      cnt        <= '0;
      overflow_o <= 1'b0;
      state      <= IDLE;
      txWr_o     <= 1'b0;
      txData_o   <= '0;
    end else begin
      if (pushOk) begin
        wp <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
      end

      case ({pushOk, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase

      // A new drop outranks a simultaneous clear.
      if (push_i && full_o) begin
        overflow_o <= 1'b1;
      end else if (clrOvf_i) begin
        overflow_o <= 1'b0;
      end

      txWr_o <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty_o && txRdy_i) begin
            state    <= ISSUE;
            txWr_o   <= 1'b1;
            txData_o <= mem[rp];
          end
        end
        ISSUE:     state <= WAIT_BUSY;
        WAIT_BUSY: if (!txRdy_i) state <= WAIT_DONE;
        WAIT_DONE: if (txRdy_i) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: vector table for fill/overflow plus
// hand-written sequences around a behavioural transmitter model.
module tb_uart_tx_fifo;

  logic        clk;
  logic        rst;
  logic        push;
  logic [7:0]  pushData;
  logic        clrOvf;
  logic        full;
  logic        empty;
  logic [4:0]  count;
  logic        overflow;
  logic        txRdy;
  logic        txWr;
  logic [7:0]  txData;

  logic        gate;
  logic        modelRdy;
  int unsigned frameLen;
  int unsigned cyc;
  int unsigned dblCnt;
  logic        prevWr;

  int unsigned checks;
  int unsigned errors;

  typedef struct {
    logic [7:0]  d;
    int unsigned c;
  } rec_t;
  rec_t txLog[$];

  typedef struct {
    logic       push;
    logic [7:0] data;
    logic       clr;
    logic [4:0] expCount;
    logic       expFull;
    logic       expEmpty;
    logic       expOvf;
  } vec_t;
  vec_t vecs[21];

  assign txRdy = gate & modelRdy;

  uart_tx_fifo #(.DEPTH(16)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .push_i     (push),
    .pushData_i (pushData),
    .clrOvf_i   (clrOvf),
    .full_o     (full),
    .empty_o    (empty),
    .count_o    (count),
    .overflow_o (overflow),
    .txRdy_i    (txRdy),
    .txWr_o     (txWr),
    .txData_o   (txData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter: rdy drops right after a write pulse and returns frameLen cycles later.
  initial begin
    modelRdy = 1'b1;
    forever begin
      @(negedge clk);
      if (txWr === 1'b1) begin
        modelRdy = 1'b0;
        repeat (frameLen) @(negedge clk);
        modelRdy = 1'b1;
      end
    end
  end

  initial begin
    dblCnt = 0;
    prevWr = 1'b0;
    forever begin
      @(negedge clk);
      if (txWr === 1'b1) begin
        txLog.push_back('{d: txData, c: cyc});
        if (prevWr) dblCnt++;
      end
      prevWr = (txWr === 1'b1);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitPulses(input int unsigned n, input int unsigned budget);
    for (int unsigned i = 0; i < budget && txLog.size() < n; i++) tick();
    check("pulse_count", txLog.size(), n);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    push     = 1'b0;
    pushData = '0;
    clrOvf   = 1'b0;
    gate     = 1'b1;
    frameLen = 20;

    for (int i = 0; i < 16; i++) begin
      vecs[i] = '{push: 1'b1, data: 8'(i), clr: 1'b0, expCount: 5'(i + 1),
                  expFull: (i == 15), expEmpty: 1'b0, expOvf: 1'b0};
    end
    vecs[16] = '{1'b1, 8'hFF, 1'b0, 5'd16, 1'b1, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 8'h00, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 8'hEE, 1'b1, 5'd16, 1'b1, 1'b0, 1'b1};
    vecs[19] = '{1'b0, 8'h00, 1'b0, 5'd16, 1'b1, 1'b0, 1'b1};
    vecs[20] = '{1'b0, 8'h00, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0};

    // Reset and idle
    repeat (2) tick();
    check("rst_empty", empty, 1'b1);
    check("rst_count", count, 5'd0);
    check("rst_full", full, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_wr", txWr, 1'b0);
    check("rst_data", txData, 8'h00);
    rst = 1'b0;
    repeat (3) tick();
    check("idle_wr", txWr, 1'b0);
    check("idle_nopulse", txLog.size(), 0);

    // Single byte: pulse lands two cycles after the push is driven
    push = 1'b1;
    pushData = 8'hA5;
    tick();
    push = 1'b0;
    check("sb_count1", count, 5'd1);
    check("sb_empty", empty, 1'b0);
    check("sb_wr_early", txWr, 1'b0);
    tick();
    check("sb_wr", txWr, 1'b1);
    check("sb_data", txData, 8'hA5);
    check("sb_count_issue", count, 5'd1);
    tick();
    check("sb_wr_off", txWr, 1'b0);
    check("sb_count0", count, 5'd0);
    repeat (25) tick();
    check("sb_one_pulse", txLog.size(), 1);
    if (txLog.size() > 0) check("sb_log_data", txLog[0].d, 8'hA5);

    // Fill and overflow vectors with the transmitter held busy
    gate = 1'b0;
    for (int i = 0; i < 21; i++) begin
      push     = vecs[i].push;
      pushData = vecs[i].data;
      clrOvf   = vecs[i].clr;
      tick();
      check($sformatf("v%0d_count", i), count, vecs[i].expCount);
      check($sformatf("v%0d_full", i), full, vecs[i].expFull);
      check($sformatf("v%0d_empty", i), empty, vecs[i].expEmpty);
      check($sformatf("v%0d_ovf", i), overflow, vecs[i].expOvf);
      check($sformatf("v%0d_wr", i), txWr, 1'b0);
    end
    push = 1'b0;
    clrOvf = 1'b0;

    // Drain in order, then push across the pointer wrap
    txLog.delete();
    frameLen = 3;
    gate = 1'b1;
    waitPulses(16, 400);
    for (int i = 0; i < 16 && i < txLog.size(); i++)
      check($sformatf("drain%0d", i), txLog[i].d, 8'(i));
    if (txLog.size() >= 2) check("pulse_gap", txLog[1].c - txLog[0].c, 5);
    for (int i = 0; i < 4; i++) begin
      push = 1'b1;
      pushData = 8'(8'h10 + i);
      tick();
    end
    push = 1'b0;
    waitPulses(20, 200);
    for (int i = 16; i < 20 && i < txLog.size(); i++)
      check($sformatf("wrap%0d", i), txLog[i].d, 8'(8'h10 + i - 16));
    repeat (10) tick();
    check("drained_empty", empty, 1'b1);
    check("drained_count", count, 5'd0);

    // Push coinciding with a pop at count 3
    gate = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push = 1'b1;
      pushData = 8'(8'h20 + i);
      tick();
    end
    push = 1'b0;
    check("pp_count3", count, 5'd3);
    gate = 1'b1;
    tick();
    check("pp_issue_wr", txWr, 1'b1);
    check("pp_issue_data", txData, 8'h20);
    push = 1'b1;
    pushData = 8'h23;
    gate = 1'b0;
    tick();
    push = 1'b0;
    check("pp_count_hold", count, 5'd3);

    // Push coinciding with a pop at count 16: dropped, overflow set
    for (int i = 0; i < 13; i++) begin
      push = 1'b1;
      pushData = 8'(8'h30 + i);
      tick();
    end
    push = 1'b0;
    check("pf_full", full, 1'b1);
    repeat (6) tick();
    gate = 1'b1;
    for (int i = 0; i < 20 && txWr !== 1'b1; i++) tick();
    check("pf_issue_wr", txWr, 1'b1);
    check("pf_count16", count, 5'd16);
    push = 1'b1;
    pushData = 8'hFF;
    tick();
    push = 1'b0;
    gate = 1'b0;
    check("pf_count15", count, 5'd15);
    check("pf_ovf", overflow, 1'b1);
    check("pf_full_off", full, 1'b0);

    // Reset during WAIT_DONE, with a push in the reset cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (12) tick();
    frameLen = 10;
    for (int i = 0; i < 5; i++) begin
      push = 1'b1;
      pushData = 8'(8'h40 + i);
      tick();
    end
    push = 1'b0;
    check("rd_count5", count, 5'd5);
    txLog.delete();
    gate = 1'b1;
    waitPulses(1, 50);
    if (txLog.size() > 0) check("rd_first", txLog[0].d, 8'h40);
    tick();
    rst = 1'b1;
    push = 1'b1;
    pushData = 8'h77;
    tick();
    rst = 1'b0;
    push = 1'b0;
    check("rd_count0", count, 5'd0);
    check("rd_empty", empty, 1'b1);
    check("rd_ovf", overflow, 1'b0);
    check("rd_wr", txWr, 1'b0);
    txLog.delete();
    repeat (30) tick();
    check("rd_no_pulse", txLog.size(), 0);
    push = 1'b1;
    pushData = 8'h5A;
    tick();
    push = 1'b0;
    waitPulses(1, 50);
    if (txLog.size() > 0) check("rd_new_data", txLog[0].d, 8'h5A);
    check("no_double_pulse", dblCnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit-side byte buffer and drain sequencer that sits directly upstream of the UART transmitter. Producers push bytes at clock rate. The block stores them in a circular FIFO and hands them one at a time to the transmitter's `wr_i`/`data_i`/`rdy_o` handshake, waiting for each frame to finish before issuing the next. This decouples bursty writers from the baud-rate-limited serial line and reports occupancy and overflow.

## Interface
- `DEPTH`, 16: number of byte entries; power of two, ≥ 2.
- `AW`, `$clog2(DEPTH)`: pointer width; derived, not overridden.
- `clk_i` in 1: system clock; the block has one clock.
- `rst_i` in 1: synchronous, active-high reset.
- `push_i` in 1: write strobe; one byte per cycle while high.
- `pushData_i` in 8: byte to enqueue, sampled when `push_i` is high.
- `clrOvf_i` in 1: clears the sticky overflow flag.
- `full_o` out 1: FIFO holds `DEPTH` bytes.
- `empty_o` out 1: FIFO holds 0 bytes.
- `count_o` out AW+1: current occupancy, 0..`DEPTH`.
- `overflow_o` out 1: sticky; a push was dropped.
- `txRdy_i` in 1: transmitter `rdy_o`; high when it is idle.
- `txWr_o` out 1: one-cycle write pulse to the transmitter `wr_i`.
- `txData_o` out 8: byte to the transmitter `data_i`; valid while `txWr_o` is high and held until the next issue.

## Operation
- Storage: `DEPTH`×8 array with registered write pointer `wp` and read pointer `rp`, each AW bits, wrapping modulo `DEPTH`, plus an AW+1-bit counter `cnt`.
  - `full_o` = (`cnt` == `DEPTH`).
  - `empty_o` = (`cnt` == 0).
  - `count_o` = `cnt`.
- Push is accepted when `push_i` is high and `full_o` is low. On acceptance: `mem[wp]` ← `pushData_i`, then `wp` increments.
- Push while `full_o` is high: the byte is dropped, `wp` is unchanged, and `overflow_o` is set on the next edge.
  - This holds even if a pop occurs in the same cycle; full is judged on the pre-edge count.
- `overflow_o` stays set until `clrOvf_i` or reset. If `clrOvf_i` and a new overflow occur in the same cycle, set wins.
- A pop happens only in state ISSUE: `txData_o` ← `mem[rp]`, then `rp` increments.
- Counter update:
  - Accepted push without pop: +1.
  - Pop without push: −1.
  - Both in the same cycle: unchanged.
- Drain FSM, states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE:
  - IDLE: if `!empty_o && txRdy_i`, go to ISSUE; otherwise stay.
  - ISSUE (one cycle): `txWr_o` = 1, pop, go to WAIT_BUSY.
  - WAIT_BUSY: stay while `txRdy_i` = 1; go to WAIT_DONE when `txRdy_i` = 0. The transmitter contract is that `rdy_o` drops within one cycle of `wr_i`.
  - WAIT_DONE: stay while `txRdy_i` = 0; go to IDLE when `txRdy_i` = 1.
- `txWr_o` is registered and is high only in ISSUE.
- Reset mid-operation:
  - FIFO is flushed and the FSM returns to IDLE.
  - A byte already issued to the transmitter is not recalled.
  - Pushes in the reset cycle are ignored.

## Timing
- Reset values:
  - `txWr_o` = 0, `txData_o` = 8'h00.
  - `count_o` = 0, `empty_o` = 1, `full_o` = 0, `overflow_o` = 0.
  - `wp` = `rp` = 0, state = IDLE.
- Push into an empty FIFO at edge N with `txRdy_i` = 1:
  - `empty_o` falls after edge N.
  - State enters ISSUE at edge N+1, so `txWr_o` and `txData_o` are valid in the cycle after edge N+1.
  - Byte-in to write-pulse latency is 2 cycles.
- Back-to-back frames: minimum spacing between `txWr_o` pulses is ISSUE + WAIT_BUSY(≥1) + WAIT_DONE + IDLE, i.e. 1 cycle after `txRdy_i` reasserts plus 1 IDLE cycle.
- Pointer wrap: after `DEPTH` accepted pushes, `wp` returns to 0; `rp` wraps the same way.
- Throughput is one push per cycle. Drain is limited by the transmitter, one byte per frame.

## Test plan
- Reset and idle: assert `rst_i` 2 cycles, release -> `empty_o`=1, `count_o`=0, `txWr_o`=0, `overflow_o`=0; the FSM remains in IDLE with `txRdy_i`=1.
- Single byte: push 8'hA5 with `txRdy_i`=1 -> `txWr_o` pulses exactly one cycle, 2 cycles after the push, with `txData_o`=8'hA5; `count_o` goes 1 then 0. The model drops `txRdy_i` for 20 cycles, and no second pulse occurs.
- Ordering and wrap: with `txRdy_i`=0, push 8'h00..8'h0F (`DEPTH`=16) -> `full_o`=1, `count_o`=16. Release `txRdy_i` with the behavioural transmitter model -> 16 pulses carrying 8'h00..8'h0F in order. Then push 8'h10..8'h13 -> issued in order across the pointer wrap.
- Overflow: fill to 16, push 8'hFF -> byte dropped, `overflow_o`=1 next cycle, `count_o` stays 16. Pulse `clrOvf_i` -> `overflow_o`=0. Assert `clrOvf_i` together with another dropped push -> `overflow_o` stays 1.
- Simultaneous push/pop: with `count_o`=3, push while the FSM is in ISSUE -> `count_o` stays 3. Repeat at `count_o`=16 -> push is dropped, `count_o`=15, `overflow_o`=1.
- Reset mid-drain: 5 bytes queued, assert `rst_i` during WAIT_DONE -> next cycle `count_o`=0, `empty_o`=1, state IDLE. No `txWr_o` occurs after `txRdy_i` returns until a new push.
